// File: rtl/i2s_rx.sv
// I2S receiver: oversamples Wclk/Bclk/i2s_in on clk and recovers MSB-first stereo frames.
// Latency: valid/err registered SYNC_STAGES+1..SYNC_STAGES+2 clk after the pin Bclk rising edge.
// No backpressure: valid/err are single-cycle strobes; DLeft/DRight hold until the next valid.
module i2s_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Wclk,
    input  logic             Bclk,
    input  logic             i2s_in,
    output logic [WIDTH-1:0] DLeft,
    output logic [WIDTH-1:0] DRight,
    output logic             valid,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        UNSYNC,
        DELAY,
        SHIFT,
        HOLD
    } state_t;

    logic [SYNC_STAGES-1:0] wclk_sync_q;
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   bclk_prev_q;

    state_t           state_q;
    logic             ws_prev_q;
    logic             chan_q;
    logic             left_ok_q;
    logic [CW-1:0]    bitcnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] pend_left_q;

    logic             ws;
    logic             sd;
    logic             rise;
    logic [WIDTH:0]   shift_ext;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    bitcnt_d;
    logic             slot_done;

    // All three inputs travel through identical synchronizer depths so data stays aligned to Bclk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wclk_sync_q <= '0;
            bclk_sync_q <= '0;
            din_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            wclk_sync_q <= {wclk_sync_q[SYNC_STAGES-2:0], Wclk};
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], Bclk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], i2s_in};
            bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign ws   = wclk_sync_q[SYNC_STAGES-1];
    assign sd   = din_sync_q[SYNC_STAGES-1];
    assign rise = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;

    // Next shift value and bit count; DELAY enters with bitcnt 0 so the same path covers both states.
    always_comb begin
        shift_ext = {shift_q, sd};
        shift_d   = shift_ext[WIDTH-1:0];
        bitcnt_d  = bitcnt_q + CW'(1);
        slot_done = (bitcnt_d == CW'(WIDTH));
    end

    // Slot/frame FSM, advanced only on synchronized Bclk rising edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNSYNC;
            ws_prev_q   <= 1'b0;
            chan_q      <= 1'b0;
            left_ok_q   <= 1'b0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            pend_left_q <= '0;
            DLeft       <= '0;
            DRight      <= '0;
            valid       <= 1'b0;
            err         <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (rise) begin
                ws_prev_q <= ws;
                if (ws != ws_prev_q) begin
                    // Word-select edge: this bit is the I2S delay bit and is not captured.
                    if (state_q == SHIFT) begin
                        err       <= 1'b1;
                        left_ok_q <= 1'b0;
                    end
                    chan_q   <= ws;
                    bitcnt_q <= '0;
                    state_q  <= DELAY;
                end else begin
                    case (state_q)
                        DELAY, SHIFT: begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_d;
                            if (slot_done) begin
                                state_q <= HOLD;
                                if (!chan_q) begin
                                    pend_left_q <= shift_d;
                                    left_ok_q   <= 1'b1;
                                end else if (left_ok_q) begin
                                    DLeft     <= pend_left_q;
                                    DRight    <= shift_d;
                                    valid     <= 1'b1;
                                    left_ok_q <= 1'b0;
                                end
                            end else begin
                                state_q <= SHIFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
